// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one shift-subtract step per clock, registered
// quotient/remainder with a single-cycle done pulse and divide-by-zero flag.
module div_seq_ctrl #(
  parameter int unsigned size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [size-1:0] consult,
  output logic [size-1:0] remainder
);

  localparam int unsigned CW = (size > 2) ? $clog2(size) : 1;
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [size-1:0] b_q;
  logic [size:0]   r_q;
  logic [size-1:0] q_q;
  logic            busy_q, done_q, dz_q;
  logic [size-1:0] cons_q, rem_q;

  logic [size:0]   t_d, r_d;
  logic [size-1:0] q_d;
  logic            ge_d;

  // One restoring step; all arithmetic kept at size+1 bits.
  always_comb begin
    t_d  = {r_q[size-1:0], q_q[size-1]};
    ge_d = (t_d >= {1'b0, b_q});
    r_d  = ge_d ? (t_d - {1'b0, b_q}) : t_d;
    q_d  = {q_q[size-2:0], ge_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      cons_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            b_q     <= b;
            q_q     <= a;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Zero divisor finishes on the first RUN edge; q_q still holds a.
          if (b_q == '0) begin
            cons_q  <= '1;
            rem_q   <= q_q;
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            r_q   <= r_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              cons_q  <= q_d;
              rem_q   <= r_d[size-1:0];
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign consult   = cons_q;
  assign remainder = rem_q;

endmodule
